// File: rtl/truth_table_sweeper.sv
// Exhaustively sweeps a 4-input combinational gate through all 16 input vectors,
// captures its truth table and compares it against a golden table latched at start.
module truth_table_sweeper #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] captured_table,
    output logic        mismatch,
    output logic [4:0]  err_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  idx;
    logic [3:0]  settle_cnt;
    logic [15:0] expected_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                next_state = (idx == 4'd15) ? ST_DONE : ST_SETTLE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // idx wraps 15 -> 0 on the final sample, so the stimulus reads 0000 during DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx            <= 4'd0;
            settle_cnt     <= 4'd0;
            expected_q     <= 16'h0000;
            captured_table <= 16'h0000;
            mismatch       <= 1'b0;
            err_count      <= 5'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx            <= 4'd0;
                        settle_cnt     <= 4'd0;
                        expected_q     <= expected;
                        captured_table <= 16'h0000;
                        mismatch       <= 1'b0;
                        err_count      <= 5'd0;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= (settle_cnt == SETTLE_LAST) ? 4'd0 : settle_cnt + 4'd1;
                end
                ST_SAMPLE: begin
                    captured_table[idx] <= f_in;
                    if (f_in != expected_q[idx]) begin
                        err_count <= err_count + 5'd1;
                        mismatch  <= 1'b1;
                    end
                    idx <= idx + 4'd1;
                end
                default: begin
                    idx <= 4'd0;
                end
            endcase
        end
    end

    assign {a, b, c, d} = idx;
    assign busy         = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a table of full sweeps on a SETTLE=1 instance,
// plus hand-written sequences for settle timing, ignored restarts and mid-sweep reset.
module tb_truth_table_sweeper;

    typedef struct {
        int          mode;
        logic [15:0] exp_in;
        logic [15:0] tbl;
        logic        mism;
        logic [4:0]  errs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start3;
    logic [15:0] expected;
    logic [15:0] expected3;
    logic        f_in;
    logic        f_in3;
    logic        a, b, c, d, busy, done, mismatch;
    logic        a3, b3, c3, d3, busy3, done3, mismatch3;
    logic [15:0] captured_table;
    logic [15:0] captured_table3;
    logic [4:0]  err_count;
    logic [4:0]  err_count3;

    int mode;
    int cyc = 0;
    int start_edge;
    int done_count = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (done === 1'b1) done_count++;

    // The gate under test for the SETTLE=1 instance is selectable; the SETTLE=3 one is parity.
    assign f_in  = (mode == 0) ? ((a & b) | (c & d)) : (mode == 1) ? 1'b1 : 1'b0;
    assign f_in3 = a3 ^ b3 ^ c3 ^ d3;

    truth_table_sweeper #(.SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .f_in(f_in),
        .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done),
        .captured_table(captured_table), .mismatch(mismatch), .err_count(err_count)
    );

    truth_table_sweeper #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .expected(expected3), .f_in(f_in3),
        .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
        .captured_table(captured_table3), .mismatch(mismatch3), .err_count(err_count3)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    // Called at a falling edge; the following rising edge is the start edge.
    task automatic launch(input int m, input logic [15:0] e);
        mode       = m;
        expected   = e;
        start      = 1'b1;
        start_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
            lat = -1;
        end else begin
            lat = cyc - start_edge;
        end
    endtask

    task automatic applyStimulus(input int m, input logic [15:0] e, output int lat);
        @(negedge clk);
        launch(m, e);
        checkOutput("busy_after_start", busy, 1'b1);
        waitDone(lat);
    endtask

    initial begin
        vec_t vecs[6];
        int   lat;
        int   base;
        int   hold_err;

        vecs[0] = '{0, 16'hF888, 16'hF888, 1'b0, 5'd0};
        vecs[1] = '{1, 16'h0000, 16'hFFFF, 1'b1, 5'd16};
        vecs[2] = '{0, 16'hF889, 16'hF888, 1'b1, 5'd1};
        vecs[3] = '{1, 16'hFFFF, 16'hFFFF, 1'b0, 5'd0};
        vecs[4] = '{0, 16'h0000, 16'hF888, 1'b1, 5'd7};
        vecs[5] = '{2, 16'h0001, 16'h0000, 1'b1, 5'd1};

        rst       = 1'b1;
        start     = 1'b0;
        start3    = 1'b0;
        mode      = 0;
        expected  = 16'h0000;
        expected3 = 16'h0000;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_abcd", {a, b, c, d}, 4'h0);
        checkOutput("reset_table", captured_table, 16'h0000);
        checkOutput("reset_err", {mismatch, err_count}, 6'h00);
        checkOutput("reset_dut3", {busy3, done3, captured_table3, err_count3}, 23'h0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            base = done_count;
            applyStimulus(vecs[i].mode, vecs[i].exp_in, lat);
            checkOutput($sformatf("v%0d_latency", i), lat, 32);
            checkOutput($sformatf("v%0d_done_abcd", i), {busy, a, b, c, d}, 5'h00);
            @(negedge clk);
            checkOutput($sformatf("v%0d_done_pulses", i), done_count - base, 1);
            checkOutput($sformatf("v%0d_done_low", i), done, 1'b0);
            checkOutput($sformatf("v%0d_table", i), captured_table, vecs[i].tbl);
            checkOutput($sformatf("v%0d_mismatch", i), mismatch, vecs[i].mism);
            checkOutput($sformatf("v%0d_err_count", i), err_count, vecs[i].errs);
        end

        // SETTLE=3 parity sweep: each vector must be held exactly four cycles, ascending.
        @(negedge clk);
        expected3 = 16'h6996;
        start3    = 1'b1;
        @(negedge clk);
        start3    = 1'b0;
        expected3 = 16'h0000;
        hold_err  = 0;
        for (int l = 0; l < 64; l++) begin
            if ({a3, b3, c3, d3} !== 4'(l / 4) || done3 !== 1'b0 || busy3 !== 1'b1) hold_err++;
            @(negedge clk);
        end
        checkOutput("s3_hold_sequence", hold_err, 0);
        checkOutput("s3_done_at_64", done3, 1'b1);
        checkOutput("s3_table", captured_table3, 16'h6996);
        checkOutput("s3_err", {mismatch3, err_count3}, 6'h00);

        // Restart request and expected change mid-sweep, plus start during DONE: all ignored.
        @(negedge clk);
        base = done_count;
        launch(0, 16'hF888);
        repeat (10) @(negedge clk);
        start    = 1'b1;
        expected = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        waitDone(lat);
        checkOutput("restart_latency", lat, 32);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("restart_idle_after_done", {busy, done}, 2'b00);
        @(negedge clk);
        checkOutput("restart_no_queue", busy, 1'b0);
        checkOutput("restart_done_pulses", done_count - base, 1);
        checkOutput("restart_table", captured_table, 16'hF888);
        checkOutput("restart_err", {mismatch, err_count}, 6'h00);

        // Asynchronous reset during vector 7 aborts the sweep with no done pulse.
        @(negedge clk);
        base = done_count;
        launch(1, 16'h0000);
        repeat (14) @(negedge clk);
        checkOutput("abort_vector7", {a, b, c, d}, 4'h7);
        checkOutput("abort_partial_table", captured_table, 16'h007F);
        checkOutput("abort_partial_err", err_count, 5'd7);
        #1 rst = 1'b1;
        #1;
        checkOutput("abort_async_clear", {busy, done, a, b, c, d, mismatch, err_count}, 12'h000);
        checkOutput("abort_table_clear", captured_table, 16'h0000);
        repeat (3) @(negedge clk);
        checkOutput("abort_no_done", done_count - base, 0);
        rst = 1'b0;
        launch(0, 16'hF888);
        checkOutput("post_reset_start_accepted", busy, 1'b1);
        waitDone(lat);
        checkOutput("post_reset_latency", lat, 32);
        @(negedge clk);
        checkOutput("post_reset_table", captured_table, 16'hF888);
        checkOutput("post_reset_err", {mismatch, err_count}, 6'h00);
        checkOutput("post_reset_done_pulses", done_count - base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
